// File: rtl/ahb_lite_pkg.sv
// AHB-Lite encodings, SRAM slave FSM states and byte-lane helper.
// Shared by ahb_sram_slave and its storage array.
`timescale 1ns/1ps
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Little-endian lane mask for an access of the given size.
    function automatic logic [3:0] byte_en(
        input logic [2:0] size,
        input logic [1:0] a
    );
        logic [3:0] m;
        m = 4'b0000;
        unique case (1'b1)
            size == HSIZE_BYTE: m = 4'b0001 << a;
            size == HSIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            size == HSIZE_WORD: m = 4'b1111;
            default:            m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-wide storage with per-byte write enables and async read.
// Drop-in point for a vendor SRAM macro wrapper.
`timescale 1ns/1ps
module ahb_sram_array #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder with wait states and two-cycle ERROR.
// Define AHB_SRAM_PRIV_EN to reject unprivileged writes.
`timescale 1ns/1ps
module ahb_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH:0] LIMIT =
        (ADDR_WIDTH+1)'(MEM_WORDS * 4);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t        state;
    state_t        state_nx;
    state_t        launch;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nx;
    logic          dp_act;
    logic          dp_wr;
    logic [AW-1:0] dp_addr;
    logic [3:0]    dp_be;
    logic          accept;
    logic          illegal;
    logic          priv_bad;
    logic          mem_we;
    logic          rd_phase;
    logic [31:0]   mem_rdata;
    logic          unused_ok;

    assign accept = HSEL & HREADY & HTRANS[1];

`ifdef AHB_SRAM_PRIV_EN
    assign priv_bad  = HWRITE & ~HPROT[1];
    assign unused_ok = ^{HTRANS[0], HPROT[3:2], HPROT[0]};
`else
    assign priv_bad  = 1'b0;
    assign unused_ok = ^{HTRANS[0], HPROT};
`endif

    assign illegal = ({1'b0, HADDR} >= LIMIT)
                   | (HSIZE > HSIZE_WORD)
                   | ((HSIZE == HSIZE_HALF) & HADDR[0])
                   | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00))
                   | priv_bad;

    always_comb begin
        if (illegal) begin
            launch = ST_ERR1;
        end else if (WAIT_STATES > 0) begin
            launch = ST_WAIT;
        end else begin
            launch = ST_IDLE;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            dp_act  <= 1'b0;
            dp_wr   <= 1'b0;
            dp_addr <= '0;
            dp_be   <= 4'b0000;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            // Address phase only advances when the bus is ready.
            if (HREADY) begin
                dp_act  <= accept & ~illegal;
                dp_wr   <= HWRITE;
                dp_addr <= HADDR[AW+1:2];
                dp_be   <= byte_en(HSIZE, HADDR[1:0]);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        unique case (state)
            ST_IDLE: begin
                state_nx = accept ? launch : ST_IDLE;
                if (accept) cnt_nx = WS;
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                cnt_nx    = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = ST_IDLE;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_nx  = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP    = HRESP_ERROR;
                state_nx = accept ? launch : ST_IDLE;
                if (accept) cnt_nx = WS;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign mem_we   = dp_act & dp_wr & (state == ST_IDLE);
    assign rd_phase = dp_act & ~dp_wr & (state == ST_IDLE);
    assign HRDATA   = rd_phase ? mem_rdata : 32'd0;

    ahb_sram_array #(
        .WORDS(MEM_WORDS),
        .AW   (AW)
    ) u_array (
        .clk  (HCLK),
        .we   (mem_we),
        .be   (dp_be),
        .waddr(dp_addr),
        .wdata(HWDATA),
        .raddr(dp_addr),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: zero-wait and three-wait instances
// against a byte-array reference model.
`timescale 1ns/1ps
module tb_ahb_sram_slave;
    import ahb_lite_pkg::*;

    localparam int MW = 64;
    localparam int MB = MW * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        hsel   [2];
    logic [31:0] haddr  [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [3:0]  hprot  [2];
    logic [31:0] hwdata [2];
    logic        rdy0, rdy1, rsp0, rsp1;
    logic [31:0] rd0, rd1;

    int checks = 0;
    int errors = 0;

    logic [7:0] mb [2][MB];

    ahb_sram_slave #(.MEM_WORDS(MW), .WAIT_STATES(0), .ADDR_WIDTH(32)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]),
        .HPROT(hprot[0]), .HWDATA(hwdata[0]), .HREADY(rdy0),
        .HREADYOUT(rdy0), .HRESP(rsp0), .HRDATA(rd0)
    );

    ahb_sram_slave #(.MEM_WORDS(MW), .WAIT_STATES(3), .ADDR_WIDTH(32)) u_dut3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]),
        .HPROT(hprot[1]), .HWDATA(hwdata[1]), .HREADY(rdy1),
        .HREADYOUT(rdy1), .HRESP(rsp1), .HRDATA(rd1)
    );

    function automatic logic rdy(int d);
        return (d == 0) ? rdy0 : rdy1;
    endfunction
    function automatic logic rsp(int d);
        return (d == 0) ? rsp0 : rsp1;
    endfunction
    function automatic logic [31:0] rdd(int d);
        return (d == 0) ? rd0 : rd1;
    endfunction
    function automatic int ws(int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference legality from address range, size and alignment.
    function automatic bit legal(bit wr, int addr, int size, logic [3:0] prot);
        if (addr >= MB) return 1'b0;
        if (size > 2) return 1'b0;
        if ((addr % (1 << size)) != 0) return 1'b0;
`ifdef AHB_SRAM_PRIV_EN
        if (wr && !prot[1]) return 1'b0;
`else
        if (wr && prot === 4'bxxxx) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] mword(int d, int addr);
        int w;
        w = (addr / 4) * 4;
        return {mb[d][w+3], mb[d][w+2], mb[d][w+1], mb[d][w]};
    endfunction

    task automatic mwrite(int d, int addr, int size, logic [31:0] wd);
        for (int i = 0; i < (1 << size); i++) begin
            int a;
            a = addr + i;
            mb[d][a] = wd[8*(a%4) +: 8];
        end
    endtask

    task automatic bus_idle(int d);
        hsel[d]   = 1'b0;
        htrans[d] = HTRANS_IDLE;
        haddr[d]  = '0;
        hwrite[d] = 1'b0;
        hsize[d]  = HSIZE_WORD;
        hprot[d]  = 4'b0011;
    endtask

    task automatic xfer(
        input  int          d,
        input  bit          wr,
        input  logic [31:0] addr,
        input  logic [2:0]  size,
        input  logic [31:0] wd,
        input  logic [3:0]  prot,
        output logic [31:0] rdata,
        output logic        resp,
        output int          low,
        output logic        lowresp,
        output logic [31:0] lowdata
    );
        hsel[d]   = 1'b1;
        htrans[d] = HTRANS_NONSEQ;
        haddr[d]  = addr;
        hwrite[d] = wr;
        hsize[d]  = size;
        hprot[d]  = prot;
        @(posedge clk); #1;
        bus_idle(d);
        hwdata[d] = wd;
        low = 0; lowresp = 1'b0; lowdata = '0;
        rdata = 'x; resp = 1'bx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rdy(d)) begin
                rdata = rdd(d);
                resp  = rsp(d);
                break;
            end
            low++;
            lowresp |= rsp(d);
            lowdata |= rdd(d);
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wd;
        logic [3:0]  prot;
        logic        eresp;
        logic [31:0] erd;
    } vec_t;

    function automatic vec_t mk(bit wr, logic [31:0] a, logic [2:0] s,
                                logic [31:0] wd, logic [3:0] p,
                                logic er, logic [31:0] erd);
        vec_t v;
        v.wr = wr; v.addr = a; v.size = s; v.wd = wd;
        v.prot = p; v.eresp = er; v.erd = erd;
        return v;
    endfunction

    initial begin
        vec_t        tbl[$];
        logic [31:0] rdata, lowdata, old, pa[4];
        logic        resp, lowresp;
        int          low, cyc, done, idx;

        rst_n = 1'b0;
        bus_idle(0); bus_idle(1);
        hwdata[0] = '0; hwdata[1] = '0;
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", {31'd0, rdy(d)}, 32'd1);
            chk("rst_resp",  {31'd0, rsp(d)}, 32'd0);
            chk("rst_rdata", rdd(d), 32'd0);
        end
        #6 rst_n = 1'b1;
        @(posedge clk); #1;

        tbl.push_back(mk(1, 32'h10, 2, 32'h11223344, 4'h3, 0, 0));
        tbl.push_back(mk(1, 32'h13, 0, 32'hAA000000, 4'h3, 0, 0));
        tbl.push_back(mk(0, 32'h10, 2, 0, 4'h3, 0, 32'hAA223344));
        tbl.push_back(mk(1, 32'h10, 1, 32'h00005566, 4'h3, 0, 0));
        tbl.push_back(mk(0, 32'h10, 2, 0, 4'h3, 0, 32'hAA225566));
        tbl.push_back(mk(0, MB, 2, 0, 4'h3, 1, 0));
        tbl.push_back(mk(1, 32'h11, 1, 32'hFFFFFFFF, 4'h3, 1, 0));
        tbl.push_back(mk(0, 32'h10, 3, 0, 4'h3, 1, 0));
        tbl.push_back(mk(1, 32'h12, 2, 32'hFFFFFFFF, 4'h3, 1, 0));
        tbl.push_back(mk(0, 32'h10, 2, 0, 4'h3, 0, 32'hAA225566));
        tbl.push_back(mk(1, 32'h14, 2, 32'h01020304, 4'h3, 0, 0));
        tbl.push_back(mk(1, 32'h16, 1, 32'hBEEF0000, 4'h3, 0, 0));
        tbl.push_back(mk(1, 32'h15, 0, 32'h0000CC00, 4'h3, 0, 0));
        tbl.push_back(mk(0, 32'h14, 2, 0, 4'h3, 0, 32'hBEEFCC04));
`ifdef AHB_SRAM_PRIV_EN
        tbl.push_back(mk(1, 32'h18, 2, 32'h12345678, 4'h3, 0, 0));
        tbl.push_back(mk(1, 32'h18, 2, 32'hFFFFFFFF, 4'h1, 1, 0));
        tbl.push_back(mk(0, 32'h18, 2, 0, 4'h1, 0, 32'h12345678));
        tbl.push_back(mk(1, 32'h18, 2, 32'h0BADF00D, 4'h3, 0, 0));
        tbl.push_back(mk(0, 32'h18, 2, 0, 4'h3, 0, 32'h0BADF00D));
`endif
        foreach (tbl[i]) begin
            xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wd,
                 tbl[i].prot, rdata, resp, low, lowresp, lowdata);
            chk($sformatf("tbl%0d_resp", i), {31'd0, resp}, {31'd0, tbl[i].eresp});
            chk($sformatf("tbl%0d_low", i), low, tbl[i].eresp ? 1 : 0);
            chk($sformatf("tbl%0d_lowresp", i), {31'd0, lowresp}, {31'd0, tbl[i].eresp});
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].erd);
        end

        // Back-to-back write then read of the same word.
        hsel[0] = 1'b1; htrans[0] = HTRANS_NONSEQ; haddr[0] = 32'h10;
        hwrite[0] = 1'b1; hsize[0] = HSIZE_WORD; hprot[0] = 4'h3;
        @(posedge clk); #1;
        hwrite[0] = 1'b0; hwdata[0] = 32'hDEADBEEF;
        @(negedge clk);
        chk("raw_wr_ready", {31'd0, rdy0}, 32'd1);
        chk("raw_wr_resp",  {31'd0, rsp0}, 32'd0);
        @(posedge clk); #1;
        bus_idle(0);
        @(negedge clk);
        chk("raw_rd_ready", {31'd0, rdy0}, 32'd1);
        chk("raw_rd_resp",  {31'd0, rsp0}, 32'd0);
        chk("raw_rd_data",  rd0, 32'hDEADBEEF);
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < MW; w++) begin
                logic [31:0] v;
                v = $urandom;
                xfer(d, 1, w*4, HSIZE_WORD, v, 4'h3,
                     rdata, resp, low, lowresp, lowdata);
                chk("fill_resp", {31'd0, resp}, 32'd0);
                mwrite(d, w*4, 2, v);
            end
        end

        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 60; n++) begin
                bit          wr, lg;
                int          sz, a, r;
                logic [3:0]  p;
                logic [31:0] v, erd;
                wr = 1'($urandom % 2);
                r  = $urandom % 10;
                sz = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
                if ($urandom % 8 == 0) a = MB + ($urandom % 64);
                else a = $urandom % MB;
                if ($urandom % 4 != 0 && sz < 3) a = a & ~((1 << sz) - 1);
`ifdef AHB_SRAM_PRIV_EN
                p = ($urandom % 3 == 0) ? 4'h1 : 4'h3;
`else
                p = 4'($urandom);
`endif
                v  = $urandom;
                lg = legal(wr, a, sz, p);
                erd = (lg && !wr) ? mword(d, a) : 32'd0;
                xfer(d, wr, a, 3'(sz), v, p, rdata, resp, low, lowresp, lowdata);
                chk("rnd_resp", {31'd0, resp}, {31'd0, !lg});
                chk("rnd_low", low, lg ? ws(d) : 1);
                chk("rnd_lowresp", {31'd0, lowresp}, {31'd0, !lg});
                chk("rnd_lowdata", lowdata, 32'd0);
                chk("rnd_rdata", rdata, erd);
                if (lg && wr) mwrite(d, a, sz, v);
            end
        end

        xfer(1, 0, 32'h24, HSIZE_WORD, 0, 4'h3, rdata, resp, low, lowresp, lowdata);
        chk("ws3_low", low, 3);
        chk("ws3_data", rdata, mword(1, 32'h24));

        // Four pipelined reads through three wait states each.
        for (int i = 0; i < 4; i++) pa[i] = 32'(i * 4);
        hsel[1] = 1'b1; htrans[1] = HTRANS_NONSEQ; haddr[1] = pa[0];
        hwrite[1] = 1'b0; hsize[1] = HSIZE_WORD;
        @(posedge clk); #1;
        idx = 1; haddr[1] = pa[1];
        cyc = 0; done = 0;
        while (done < 4 && cyc < 40) begin
            logic r;
            @(negedge clk);
            cyc++;
            r = rdy1;
            if (r) begin
                chk($sformatf("pipe%0d_data", done), rd1, mword(1, done*4));
                done++;
            end
            @(posedge clk); #1;
            if (r) begin
                idx++;
                if (idx < 4) haddr[1] = pa[idx];
                else bus_idle(1);
            end
        end
        chk("pipe_cycles", cyc, 16);
        bus_idle(1);
        @(posedge clk); #1;

        // Reset in the second wait cycle of a write.
        old = mword(1, 32'h20);
        hsel[1] = 1'b1; htrans[1] = HTRANS_NONSEQ; haddr[1] = 32'h20;
        hwrite[1] = 1'b1; hsize[1] = HSIZE_WORD; hprot[1] = 4'h3;
        @(posedge clk); #1;
        bus_idle(1);
        hwdata[1] = ~old;
        @(posedge clk); #1;
        chk("mid_wait_ready", {31'd0, rdy1}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'd0, rdy1}, 32'd1);
        chk("arst_resp",  {31'd0, rsp1}, 32'd0);
        chk("arst_rdata", rd1, 32'd0);
        @(posedge clk); #1;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 0, 32'h20, HSIZE_WORD, 0, 4'h3, rdata, resp, low, lowresp, lowdata);
        chk("arst_mem_kept", rdata, old);
        chk("arst_post_low", low, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
